// File: rtl/div_clock_monitor.sv
// Receives a slow divided clock in the fast domain: synchronizes it, emits rise/fall
// enables, measures period and high time, and flags a missing slow clock.
module div_clock_monitor #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned COUNT_WIDTH = 20,
   parameter int unsigned TIMEOUT     = 1000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   slow_in,
   input  logic                   enable,
   output logic                   rise_pulse,
   output logic                   fall_pulse,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] high_time,
   output logic                   period_valid,
   output logic                   stalled
);

   localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(TIMEOUT - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

   // Reject parameter sets the counter or synchronizer cannot honour.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("div_clock_monitor: SYNC_STAGES must be at least 2");
   end
   if (TIMEOUT < 2 || longint'(TIMEOUT) > ((64'd1 << COUNT_WIDTH) - 64'd1)) begin : g_bad_timeout
      $error("div_clock_monitor: TIMEOUT out of range for COUNT_WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   prev;
   logic                   sync_val;
   logic                   rise_c;
   logic                   fall_c;

   state_t                 state;
   state_t                 state_next;
   logic [COUNT_WIDTH-1:0] cnt;
   logic [COUNT_WIDTH-1:0] cnt_next;
   logic [COUNT_WIDTH-1:0] period_next;
   logic [COUNT_WIDTH-1:0] high_next;
   logic                   valid_next;
   logic                   stalled_next;
   logic                   rise_next;
   logic                   fall_next;

   // Synchronizer chain plus the previous-value flop; runs regardless of enable.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_chain <= '0;
         prev       <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], slow_in};
         prev       <= sync_val;
      end
   end

   assign sync_val = sync_chain[SYNC_STAGES-1];
   assign rise_c   = sync_val & ~prev;
   assign fall_c   = ~sync_val & prev;

   // State, counter and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         stalled      <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         period       <= period_next;
         high_time    <= high_next;
         period_valid <= valid_next;
         stalled      <= stalled_next;
         rise_pulse   <= rise_next;
         fall_pulse   <= fall_next;
      end
   end

   // Next-state and capture logic; disable overrides everything except stall.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      period_next  = period;
      high_next    = high_time;
      valid_next   = period_valid;
      stalled_next = stalled;
      rise_next    = rise_c & enable;
      fall_next    = fall_c & enable;

      if (!enable) begin
         state_next = IDLE;
         cnt_next   = '0;
         valid_next = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_next = '0;
               if (rise_c) begin
                  state_next   = ARMED;
                  stalled_next = 1'b0;
               end
            end
            ARMED, LOCKED: begin
               if (rise_c) begin
                  state_next   = LOCKED;
                  cnt_next     = '0;
                  period_next  = cnt + CNT_ONE;
                  valid_next   = 1'b1;
                  stalled_next = 1'b0;
               end else if (cnt == CNT_LAST) begin
                  // A rise on this same cycle would still be a legal period of TIMEOUT.
                  state_next   = IDLE;
                  cnt_next     = '0;
                  valid_next   = 1'b0;
                  stalled_next = 1'b1;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
               if (fall_c) begin
                  high_next = cnt + CNT_ONE;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

endmodule

// File: doc/div_clock_monitor.md
# div_clock_monitor

Fast-domain receiver for a slow, divided clock. It synchronizes an asynchronous slow clock input into the `clock` domain and emits one-cycle rise and fall pulses. It measures the slow signal's period and high time in `clock` cycles and flags a stalled (missing) slow clock. Downstream logic uses the pulses as clock enables and uses the measurements for self-test of the divider chain.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal values are 2 and up.
- `COUNT_WIDTH`, default 20: width of the cycle counter and of the measurement outputs.
- `TIMEOUT`, default 1000000: cycles without a rising edge before a stall is declared. Must satisfy 2 <= TIMEOUT <= 2^COUNT_WIDTH - 1.

Ports:
- `clock` input, 1: fast system clock; all logic is on its rising edge.
- `reset` input, 1: reset, asynchronous, active-high.
- `slow_in` input, 1: slow clock, asynchronous to `clock`.
- `enable` input, 1: measurement enable, synchronous.
- `rise_pulse` output, 1: one-cycle pulse per synchronized rising edge of `slow_in`.
- `fall_pulse` output, 1: one-cycle pulse per synchronized falling edge of `slow_in`.
- `period` output, COUNT_WIDTH: clock cycles between the last two rising edges.
- `high_time` output, COUNT_WIDTH: clock cycles from the last rising edge to the following falling edge.
- `period_valid` output, 1: high while `period` holds a measurement taken in the current lock.
- `stalled` output, 1: high once TIMEOUT elapses with no rising edge.

## Operation
- **Synchronizer.** A chain of SYNC_STAGES flops samples `slow_in`. One more flop holds the previous synchronized value. The chain runs regardless of `enable`.
- **Edge detection.**
  - rise = sync & ~prev.
  - fall = ~sync & prev.
  - Pulses are registered and are gated by `enable`.
- **Counter `cnt`.**
  - Cleared to 0 on a rise cycle.
  - Otherwise increments by 1 while the state is ARMED or LOCKED.
  - Held at 0 in IDLE.
  - Because TIMEOUT bounds the count, the counter never wraps.
- **States.**
  - IDLE: reset state.
    - Rise with `enable`=1 → ARMED.
    - `cnt` stays 0.
  - ARMED: first rise seen, no full period measured yet.
    - Rise → LOCKED; `period` <= `cnt`+1; `period_valid` <= 1.
    - Fall → `high_time` <= `cnt`+1.
  - LOCKED: the same captures as ARMED on each rise and fall; the state remains LOCKED.
  - From ARMED or LOCKED: if `cnt` == TIMEOUT-1 and there is no rise this cycle → IDLE, `stalled` <= 1, `period_valid` <= 0.
  - `enable`=0 in any state → IDLE next edge.
    - `cnt` <= 0 and `period_valid` <= 0.
    - `stalled` is unchanged.
- **Stall flag.**
  - `stalled` clears on the first enabled rise.
  - Because a stall takes the block from ARMED or LOCKED to IDLE, a later rise re-arms it and a second rise is needed before `period_valid` returns.
- **Simultaneous events.**
  - A rise in the cycle where `cnt` == TIMEOUT-1 is a valid measurement: `period` = TIMEOUT, no stall.
  - Rise and fall cannot coincide, because each requires a different sync value.
- **Measurement hold.** `period` and `high_time` keep their last values across IDLE. Only reset clears them.

## Timing
- **Reset values.**
  - All synchronizer flops, prev, and `cnt` = 0.
  - State = IDLE.
  - `rise_pulse`, `fall_pulse`, `period_valid` and `stalled` = 0.
  - `period` and `high_time` = 0.
- **Reset mid-operation.** Reset forces all of the above immediately and asynchronously. The first edge after reset release cannot produce a rise unless `slow_in` was sampled low first.
- **Latency.** If `slow_in` is first sampled high at clock edge N, then `rise_pulse` is high for exactly one cycle starting at edge N+SYNC_STAGES. `fall_pulse` follows the same rule.
- **Capture timing.** `period`, `high_time` and `period_valid` update on the same edge as the corresponding pulse.
- **Measurement semantics.** Rises detected at edges A and B give `period` = B−A. A rise at A followed by a fall at F gives `high_time` = F−A.
- **Minimum input.** `slow_in` high and low phases must each be at least 2 `clock` cycles. Shorter pulses may be lost; this is not a protocol error, and no flag is raised.

## Test plan
- **Steady input.** Reset, `enable`=1, `slow_in` square wave with period 10 cycles and high for 4. Required: after the second rise, `period`=10, `high_time`=4, `period_valid`=1, and exactly one `rise_pulse` and one `fall_pulse` every 10 cycles.
- **Latency.** `slow_in` driven high synchronously at edge N with SYNC_STAGES=2. Required: `rise_pulse` high during the single cycle after edge N+2 and low at N+3.
- **Stall.** TIMEOUT=50 with the input locked at period 10, then `slow_in` held constant. Required: `stalled`=1 and `period_valid`=0 exactly 50 cycles after the last rise, and `period` stays 10. Resuming the input gives `stalled`=0 at the first rise and `period_valid`=1 at the second.
- **Timeout boundary.** TIMEOUT=50 with rises spaced exactly 50 cycles apart. Required: `period`=50 and no stall. Rises spaced 51 cycles apart must give a stall.
- **Enable deassertion.** While LOCKED, drop `enable` for 30 cycles. Required: no pulses, `period_valid`=0, and `period` and `high_time` held. After re-enabling, the first rise arms the block and the second rise restores a valid `period`.
- **Reset mid-operation.** Assert `reset` mid-period. Required: all outputs are 0 immediately, and the next measurement after release is exact.
